pam4_prbs_source: RTL and testbench

- Upstream stimulus stage for the ISI channel model: generates a PAM4 symbol stream and drives the channel's 8-bit signal input and its valid strobe.
- Each burst is an optional alternating training preamble followed by PRBS7 data.
- Data is Gray-mapped onto four signed levels spaced SYMBOL_SEPARATION apart.
- One symbol is emitted every SYMBOL_PERIOD clocks; busy, done and symbol_count report progress to the testbench and controller.

---
 rtl/serdes_pkg.sv | 34 +++
 rtl/prbs7_gen.sv | 42 ++++
 rtl/pam4_prbs_source.sv | 173 +++++++++++++++++
 tb/tb_pam4_prbs_source.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the PAM4 stimulus path: burst FSM states, PRBS7
// constants and the Gray-coded PAM4 level mapping.
package serdes_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DONE     = 2'd3
    } state_t;

    // x^7 + x^6 + 1: feedback taps are bits 6 and 5 of the shift register
    localparam int         PRBS7_TAP_HI       = 6;
    localparam int         PRBS7_TAP_LO       = 5;
    localparam logic [6:0] PRBS7_DEFAULT_SEED = 7'h7F;
    localparam logic [6:0] PRBS7_ZERO_SUB     = 7'h01;

    localparam logic [1:0] GRAY_NEG3 = 2'b00;
    localparam logic [1:0] GRAY_NEG1 = 2'b01;
    localparam logic [1:0] GRAY_POS1 = 2'b11;
    localparam logic [1:0] GRAY_POS3 = 2'b10;

    function automatic int pam4_level(input logic [1:0] bits, input int sep);
        int lvl;
        case (bits)
            GRAY_NEG3: lvl = -((3 * sep) / 2);
            GRAY_NEG1: lvl = -(sep / 2);
            GRAY_POS1: lvl = sep / 2;
            default:   lvl = (3 * sep) / 2;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 shift register delivering two sequence bits per advance, first bit in
// the MSB; a zero seed is replaced so the register can never lock up.
module prbs7_gen
    import serdes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] seed,
    input  logic       advance,
    output logic [1:0] bits
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;
    logic       bit_first;
    logic       bit_second;

    // Two single steps folded together: the second feedback bit only needs
    // the taps one position lower in the pre-step register.
    assign bit_first  = lfsr_q[PRBS7_TAP_HI] ^ lfsr_q[PRBS7_TAP_LO];
    assign bit_second = lfsr_q[PRBS7_TAP_HI-1] ^ lfsr_q[PRBS7_TAP_LO-1];
    assign bits       = {bit_first, bit_second};

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == 7'd0) ? PRBS7_ZERO_SUB : seed;
        end else if (advance) begin
            lfsr_d = {lfsr_q[4:0], bit_first, bit_second};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= PRBS7_DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/pam4_prbs_source.sv
// PAM4 burst source: alternating training preamble followed by Gray-mapped
// PRBS7 data, one registered symbol strobe every SYMBOL_PERIOD clocks.
module pam4_prbs_source
    import serdes_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPARATION = 56,
    parameter int SYMBOL_PERIOD     = 4,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         seed_load,
    input  logic [6:0]                   seed,
    input  logic [7:0]                   preamble_len,
    input  logic [COUNT_WIDTH-1:0]       burst_len,
    output logic [SIGNAL_RESOLUTION-1:0] signal_out,
    output logic                         signal_out_valid,
    output logic                         busy,
    output logic                         done,
    output logic [COUNT_WIDTH-1:0]       symbol_count
);

    localparam int PERIOD_W = (SYMBOL_PERIOD > 1) ? $clog2(SYMBOL_PERIOD) : 1;
    localparam logic [PERIOD_W-1:0] PERIOD_RELOAD = PERIOD_W'(SYMBOL_PERIOD - 1);
    localparam logic [SIGNAL_RESOLUTION-1:0] PRE_HI =
        SIGNAL_RESOLUTION'(pam4_level(GRAY_POS3, SYMBOL_SEPARATION));
    localparam logic [SIGNAL_RESOLUTION-1:0] PRE_LO =
        SIGNAL_RESOLUTION'(pam4_level(GRAY_NEG3, SYMBOL_SEPARATION));

    state_t                         state_q, state_d;
    logic [PERIOD_W-1:0]            period_q, period_d;
    logic [7:0]                     pre_left_q, pre_left_d;
    logic [COUNT_WIDTH-1:0]         data_left_q, data_left_d;
    logic                           phase_q, phase_d;
    logic [SIGNAL_RESOLUTION-1:0]   signal_q, signal_d;
    logic                           valid_q, valid_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic [COUNT_WIDTH-1:0]         count_q, count_d;

    logic                           prbs_load;
    logic                           prbs_advance;
    logic [1:0]                     prbs_bits;
    logic [SIGNAL_RESOLUTION-1:0]   data_level;
    logic [COUNT_WIDTH-1:0]         count_inc;

    prbs7_gen u_prbs (
        .clk     (clk),
        .rst     (rst),
        .load    (prbs_load),
        .seed    (seed),
        .advance (prbs_advance),
        .bits    (prbs_bits)
    );

    assign data_level = SIGNAL_RESOLUTION'(pam4_level(prbs_bits, SYMBOL_SEPARATION));
    assign count_inc  = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        pre_left_d   = pre_left_q;
        data_left_d  = data_left_q;
        phase_d      = phase_q;
        signal_d     = signal_q;
        valid_d      = 1'b0;
        count_d      = count_q;
        prbs_load    = 1'b0;
        prbs_advance = 1'b0;

        if (abort) begin
            state_d  = IDLE;
            period_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    prbs_load = seed_load;
                    if (start) begin
                        pre_left_d  = preamble_len;
                        data_left_d = burst_len;
                        count_d     = '0;
                        phase_d     = 1'b0;
                        period_d    = '0;
                        if (preamble_len != 8'd0) begin
                            state_d = PREAMBLE;
                        end else if (burst_len != '0) begin
                            state_d = DATA;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                PREAMBLE: begin
                    if (period_q == '0) begin
                        valid_d    = 1'b1;
                        signal_d   = phase_q ? PRE_LO : PRE_HI;
                        phase_d    = ~phase_q;
                        count_d    = count_inc;
                        period_d   = PERIOD_RELOAD;
                        pre_left_d = pre_left_q - 8'd1;
                        if (pre_left_q == 8'd1) begin
                            state_d = (data_left_q != '0) ? DATA : DONE;
                        end
                    end else begin
                        period_d = period_q - PERIOD_W'(1);
                    end
                end
                DATA: begin
                    if (period_q == '0) begin
                        valid_d      = 1'b1;
                        signal_d     = data_level;
                        prbs_advance = 1'b1;
                        count_d      = count_inc;
                        period_d     = PERIOD_RELOAD;
                        data_left_d  = data_left_q - COUNT_WIDTH'(1);
                        if (data_left_q == COUNT_WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        period_d = period_q - PERIOD_W'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == PREAMBLE) || (state_d == DATA);
        // The completion pulse trails the DONE state by one clock; an abort
        // landing on that clock suppresses it.
        done_d = !abort && (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            period_q    <= '0;
            pre_left_q  <= '0;
            data_left_q <= '0;
            phase_q     <= 1'b0;
            signal_q    <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            pre_left_q  <= pre_left_d;
            data_left_q <= data_left_d;
            phase_q     <= phase_d;
            signal_q    <= signal_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    assign signal_out       = signal_q;
    assign signal_out_valid = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign symbol_count     = count_q;

endmodule

// File: tb/tb_pam4_prbs_source.sv
// Bench for pam4_prbs_source: a symbol-level model predicts every strobe
// (cycle and level), busy window, done cycle and count; checked each cycle.
module tb_pam4_prbs_source;

    localparam int P  = 4;
    localparam int S  = 56;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          seed_load = 1'b0;
    logic [6:0]    seed = 7'd0;
    logic [7:0]    preamble_len = 8'd0;
    logic [CW-1:0] burst_len = '0;
    logic [7:0]    signal_out;
    logic          signal_out_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] symbol_count;

    pam4_prbs_source #(
        .SIGNAL_RESOLUTION (8),
        .SYMBOL_SEPARATION (S),
        .SYMBOL_PERIOD     (P),
        .COUNT_WIDTH       (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .seed_load        (seed_load),
        .seed             (seed),
        .preamble_len     (preamble_len),
        .burst_len        (burst_len),
        .signal_out       (signal_out),
        .signal_out_valid (signal_out_valid),
        .busy             (busy),
        .done             (done),
        .symbol_count     (symbol_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } sym_t;

    sym_t       exp_q[$];
    logic [7:0] obs_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    bit         chk_en = 1'b0;
    bit         exp_valid;
    int         busy_lo = 1;
    int         busy_hi = 0;
    int         done_cyc = -1;
    int         clr_cyc = -1;
    int         exp_cnt = 0;
    logic [7:0] exp_sig = 8'd0;
    logic [6:0] model_lfsr = 7'h7F;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cyc %0d): got 0x%0h required 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One PRBS7 step at a time straight from the polynomial definition.
    function automatic logic [1:0] next_pair();
        logic [1:0] r;
        logic       b;
        r = 2'b00;
        for (int k = 0; k < 2; k++) begin
            b          = model_lfsr[6] ^ model_lfsr[5];
            model_lfsr = {model_lfsr[5:0], b};
            r          = {r[0], b};
        end
        return r;
    endfunction

    function automatic logic [7:0] level_of(input logic [1:0] b);
        int lv;
        case (b)
            2'b00:   lv = -((3 * S) / 2);
            2'b01:   lv = -(S / 2);
            2'b11:   lv = S / 2;
            default: lv = (3 * S) / 2;
        endcase
        return 8'(lv);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison against the model's expectations.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("strobe_missed_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (cyc == clr_cyc) exp_cnt = 0;
            exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            if (exp_valid) begin
                exp_sig = exp_q[0].val;
                exp_cnt++;
                void'(exp_q.pop_front());
            end
            check("valid", signal_out_valid, exp_valid);
            check("signal_out", signal_out, exp_sig);
            check("symbol_count", symbol_count, exp_cnt);
            check("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
            check("done", done, cyc == done_cyc);
            if (signal_out_valid) obs_q.push_back(signal_out);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_burst(input int pre, input int len, input int abort_k,
                             input bit ld, input logic [6:0] sd, input bit noise);
        int n, a, total, last, c, fin;
        logic [7:0] v;
        @(posedge clk);
        #1;
        n     = cyc + 1;
        total = pre + len;
        a     = (abort_k > 0) ? n + 1 + (abort_k - 1) * P + 1 : 32'h7FFF_FFFF;
        if (ld) begin
            seed_load  = 1'b1;
            seed       = sd;
            model_lfsr = (sd == 7'd0) ? 7'h01 : sd;
        end
        start        = 1'b1;
        preamble_len = 8'(pre);
        burst_len    = CW'(len);
        last         = n;
        for (int i = 0; i < total; i++) begin
            c = n + 1 + i * P;
            if (c >= a) break;
            if (i < pre) v = (i % 2 == 0) ? level_of(2'b10) : level_of(2'b00);
            else         v = level_of(next_pair());
            exp_q.push_back('{cyc: c, val: v});
            last = c;
        end
        clr_cyc = n;
        if (abort_k > 0) begin
            busy_lo = n; busy_hi = a - 1; done_cyc = -1; fin = a + 2;
        end else if (total > 0) begin
            busy_lo = n; busy_hi = last - 1; done_cyc = last + 1; fin = last + 2;
        end else begin
            busy_lo = 1; busy_hi = 0; done_cyc = n + 1; fin = n + 2;
        end
        @(posedge clk);
        #1;
        // Everything here lands while busy or in DONE and must be ignored.
        start        = noise;
        seed_load    = noise;
        seed         = 7'($urandom_range(0, 127));
        preamble_len = 8'($urandom_range(0, 255));
        burst_len    = CW'($urandom_range(0, 65535));
        @(posedge clk);
        #1;
        start     = 1'b0;
        seed_load = 1'b0;
        if (abort_k > 0) begin
            wait_until(a - 1);
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
        wait_until(fin);
    endtask

    task automatic check_obs(input string name, input logic [7:0] lits [8], input int n);
        check({name, "_count"}, obs_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < obs_q.size()) check(name, obs_q[i], lits[i]);
        end
    endtask

    initial begin
        logic [7:0] lits [8];
        logic [7:0] pin;
        int nonac, pre, len, ak, total;

        // Hand-derived PRBS7 values pin the model itself.
        lits = '{8'hAC, 8'hAC, 8'hAC, 8'h54, 8'h00, 8'h00, 8'h00, 8'h00};
        model_lfsr = 7'h7F;
        for (int i = 0; i < 4; i++) begin
            pin = level_of(next_pair());
            check("model_pin_seed7f", pin, lits[i]);
        end
        model_lfsr = 7'h01;
        pin = level_of(next_pair());
        pin = level_of(next_pair());
        pin = level_of(next_pair());
        check("model_pin_seed01_third", pin, 8'hE4);
        model_lfsr = 7'h7F;

        #1 rst = 1'b1;
        #1;
        check("reset_signal_out", signal_out, 0);
        check("reset_valid", signal_out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_count", symbol_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Seed loaded with start, plain 4-symbol burst.
        obs_q.delete();
        run_burst(0, 4, 0, 1'b1, 7'h7F, 1'b0);
        check_obs("burst4_seed7f", lits, 4);
        check("burst4_final_count", symbol_count, 4);

        // Preamble then one data symbol.
        obs_q.delete();
        lits = '{8'h54, 8'hAC, 8'h54, 8'hAC, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(3, 1, 0, 1'b1, 7'h7F, 1'b0);
        check_obs("preamble3_data1", lits, 4);

        // Abort after the second strobe, then continue from the LFSR state.
        run_burst(0, 10, 2, 1'b0, 7'h00, 1'b0);
        check("abort_frozen_count", symbol_count, 2);
        run_burst(0, 5, 0, 1'b0, 7'h00, 1'b0);

        // Zero seed substitution.
        obs_q.delete();
        lits = '{8'hAC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(0, 1, 0, 1'b1, 7'h00, 1'b0);
        check_obs("seed0_first", lits, 1);
        obs_q.delete();
        run_burst(0, 8, 0, 1'b0, 7'h00, 1'b0);
        nonac = 0;
        foreach (obs_q[i]) if (obs_q[i] != 8'hAC) nonac++;
        check("seed0_not_stuck", nonac > 0, 1);

        // Empty burst, then start/seed_load while busy.
        run_burst(0, 0, 0, 1'b0, 7'h00, 1'b0);
        run_burst(2, 6, 0, 1'b0, 7'h00, 1'b1);

        // Reset in the middle of a burst.
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; preamble_len = 8'd2; burst_len = CW'(6);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_signal_out", signal_out, 0);
        check("midreset_valid", signal_out_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_count", symbol_count, 0);
        @(posedge clk);
        #1;
        check("midreset_hold_valid", signal_out_valid, 0);
        rst = 1'b0;
        exp_q.delete();
        model_lfsr = 7'h7F;
        exp_sig = 8'd0; exp_cnt = 0;
        busy_lo = 1; busy_hi = 0; done_cyc = -1; clr_cyc = -1;
        chk_en = 1'b1;

        obs_q.delete();
        lits = '{8'hAC, 8'hAC, 8'hAC, 8'h54, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(0, 4, 0, 1'b0, 7'h00, 1'b0);
        check_obs("after_reset_seed7f", lits, 4);

        // Randomized bursts.
        for (int t = 0; t < 20; t++) begin
            pre   = $urandom_range(0, 4);
            len   = $urandom_range(0, 10);
            total = pre + len;
            ak    = (total >= 3 && $urandom_range(0, 3) == 0) ? $urandom_range(1, total - 1) : 0;
            run_burst(pre, len, ak, $urandom_range(0, 3) == 0,
                      7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("expectations_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
